bar_run_detect: RTL and testbench
=================================

Name: bar_run_detect

Overview:
Downstream consumer of the registered 8-bit operand bus `a` that the upstream reset/drive stage feeds into `bar`. The block samples `a` under a valid strobe and detects runs of a programmable match byte. It reports each completed qualifying run as a single-entry event over a valid/ready handshake, and keeps a saturating count of qualifying runs. It sits beside `bar` on the same `a` bus and uses the same clock and reset.

Parameters:
MATCH, 8'h42, byte value that constitutes a run element.
RUN_LEN, 4, consecutive matches needed to qualify a run; legal range 2..255.
CNT_W, 16, width of the qualifying-run counter.

Ports:
clk  input  1  sole clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high; clears all state immediately.
a  input  8  operand byte from the upstream stage.
a_vld  input  1  `a` is sampled only when high.
evt_rdy  input  1  consumer accepts the event when high together with evt_vld.
evt_vld  output  1  event register holds an unconsumed event.
evt_len  output  8  length of the reported run; saturates at 255.
hit_cnt  output  CNT_W  number of runs that reached RUN_LEN; saturating.
ovf  output  1  sticky flag: an event was dropped.
busy  output  1  high when the FSM is in RUN or LOCK.

Behaviour:
- Reset values: evt_vld=0, evt_len=8'h00, hit_cnt=0, ovf=0, busy=0, FSM=IDLE, run_len=0. Reset is asserted asynchronously and released synchronously to clk.
- Sample condition: a_vld=1. Match = sample and a==MATCH. Miss = sample and a!=MATCH. When a_vld=0, all FSM and counter state holds.
- IDLE:
  - On a match: go to RUN, run_len=1.
  - On a miss: stay in IDLE.
- RUN:
  - On a match: run_len+1. If the new run_len==RUN_LEN, go to LOCK and increment hit_cnt (saturate at all-ones) on the same edge.
  - On a miss: go to IDLE, run_len=0. No event is generated.
- LOCK:
  - On a match: run_len+1, saturating at 255.
  - On a miss: go to IDLE, run_len=0, and generate an event with length = run_len (the value before the miss).
- busy = (FSM != IDLE), registered.
- Latency:
  - The FSM moves to LOCK and hit_cnt updates on the edge that samples the RUN_LEN-th match.
  - evt_vld rises on the edge that samples the terminating miss. It is visible the cycle after that miss is presented.
- Event register (single entry):
  - Consume = evt_vld and evt_rdy. On consume, evt_vld clears on the next edge unless a new event is loaded on the same edge.
  - New event while empty, or while being consumed the same cycle: load evt_len and set evt_vld=1. The old event is considered delivered.
  - New event while evt_vld=1 and evt_rdy=0: drop the new event, keep the old one, set ovf=1.
  - ovf stays set until reset.
  - evt_len is stable whenever evt_vld=1 and not consumed.
- Boundaries:
  - A run of exactly RUN_LEN-1 matches followed by a miss produces no event and no hit_cnt change.
  - A run that is still in LOCK never emits an event until a miss arrives. Holding a_vld=0 indefinitely keeps it pending.
  - Runs longer than 255 report evt_len=255.
  - When hit_cnt is at all-ones, further qualifying runs leave it unchanged.
  - Reset during RUN or LOCK discards the run with no event. Reset clears a pending event and ovf.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then apply 6 valid bytes of 8'h42 followed by 8'h00, with evt_rdy=1 -> hit_cnt=1 one cycle after the 4th byte; evt_vld pulses for one cycle with evt_len=6.
2. Apply 3x 8'h42 then 8'h10 -> no event; hit_cnt=0; busy=1 for 3 cycles then 0.
3. Apply 5x 8'h42 with a_vld toggling 1,0,1,0,... then 8'h00 -> only valid bytes count; event reports evt_len=5.
4. With evt_rdy=0, complete two qualifying runs of length 4 and 7 -> evt_len=4 is held; ovf=1 after the second run's miss. Then raise evt_rdy -> evt_vld clears on the next cycle.
5. Raise evt_rdy on the same cycle that a new run terminates -> the old event is consumed, the new event is loaded, evt_vld stays 1, and ovf=0.
6. Assert rst asynchronously mid-LOCK (run_len=5) and mid-clock-period -> all outputs drop immediately to reset values. No event is emitted after release. A 300-byte run then reports evt_len=255.

Source files
------------

// File: rtl/bar_run_detect.sv
// bar_run_detect: watches the registered operand bus `a` for runs of a match
// byte, reports each qualifying run over a single-entry valid/ready event
// register and keeps a saturating count of qualifying runs.
module bar_run_detect #(
    parameter logic [7:0]  MATCH   = 8'h42,
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       a,
    input  logic             a_vld,
    input  logic             evt_rdy,
    output logic             evt_vld,
    output logic [7:0]       evt_len,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             ovf,
    output logic             busy
);

    localparam logic [7:0]       RUN_LEN_B = 8'(RUN_LEN);
    localparam logic [7:0]       LEN_MAX   = 8'hFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       run_len_q, run_len_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             evt_vld_q, evt_vld_d;
    logic [7:0]       evt_len_q, evt_len_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             is_match, is_miss, new_evt;

    // State and output registers; everything the block drives out lives here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            run_len_q <= 8'h00;
            hit_cnt_q <= '0;
            evt_vld_q <= 1'b0;
            evt_len_q <= 8'h00;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            hit_cnt_q <= hit_cnt_d;
            evt_vld_q <= evt_vld_d;
            evt_len_q <= evt_len_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
        end
    end

    // Run tracking, hit counting and single-entry event register update.
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        hit_cnt_d = hit_cnt_q;
        evt_vld_d = evt_vld_q;
        evt_len_d = evt_len_q;
        ovf_d     = ovf_q;
        new_evt   = 1'b0;
        is_match  = a_vld && (a == MATCH);
        is_miss   = a_vld && (a != MATCH);

        case (state_q)
            IDLE: begin
                if (is_match) begin
                    state_d   = RUN;
                    run_len_d = 8'd1;
                end
            end
            RUN: begin
                if (is_match) begin
                    run_len_d = run_len_q + 8'd1;
                    if (run_len_d == RUN_LEN_B) begin
                        state_d = LOCK;
                        if (hit_cnt_q != CNT_MAX) begin
                            hit_cnt_d = hit_cnt_q + CNT_W'(1);
                        end
                    end
                end else if (is_miss) begin
                    state_d   = IDLE;
                    run_len_d = 8'h00;
                end
            end
            LOCK: begin
                if (is_match) begin
                    if (run_len_q != LEN_MAX) begin
                        run_len_d = run_len_q + 8'd1;
                    end
                end else if (is_miss) begin
                    state_d   = IDLE;
                    run_len_d = 8'h00;
                    new_evt   = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                run_len_d = 8'h00;
            end
        endcase

        // A consume frees the slot on this edge, so a same-cycle event may load.
        if (new_evt) begin
            if (!evt_vld_q || evt_rdy) begin
                evt_vld_d = 1'b1;
                evt_len_d = run_len_q;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (evt_vld_q && evt_rdy) begin
            evt_vld_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign evt_vld = evt_vld_q;
    assign evt_len = evt_len_q;
    assign hit_cnt = hit_cnt_q;
    assign ovf     = ovf_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_bar_run_detect.sv
// Testbench for bar_run_detect: directed scenarios plus random traffic, with a
// run-counting reference model feeding an event scoreboard.
module tb_bar_run_detect;

    localparam logic [7:0]  MATCH   = 8'h42;
    localparam int unsigned RUN_LEN = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       a = 8'h00;
    logic             a_vld = 1'b0;
    logic             evt_rdy = 1'b0;
    logic             evt_vld;
    logic [7:0]       evt_len;
    logic [CNT_W-1:0] hit_cnt;
    logic             ovf;
    logic             busy;

    int total = 0;
    int bad   = 0;

    // Reference model: length of current streak of valid matches, and the
    // observable consequences of streaks ending.
    int unsigned m_streak = 0;
    int unsigned m_hits   = 0;
    bit          m_pend   = 1'b0;
    bit          m_ovf    = 1'b0;
    int unsigned exp_q[$];

    bar_run_detect #(.MATCH(MATCH), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .a(a), .a_vld(a_vld), .evt_rdy(evt_rdy),
        .evt_vld(evt_vld), .evt_len(evt_len), .hit_cnt(hit_cnt),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_streak = 0;
        m_hits   = 0;
        m_pend   = 1'b0;
        m_ovf    = 1'b0;
        exp_q.delete();
    endtask

    // Effect of one clock edge with the given inputs.
    task automatic model_step(input logic [7:0] av, input logic v, input logic r);
        bit          fire = 1'b0;
        int unsigned len  = 0;
        bit          cons = m_pend && r;
        if (v) begin
            if (av == MATCH) begin
                m_streak++;
                if (m_streak == RUN_LEN && m_hits < CNT_MAX) m_hits++;
            end else begin
                if (m_streak >= RUN_LEN) begin
                    fire = 1'b1;
                    len  = (m_streak > 255) ? 255 : m_streak;
                end
                m_streak = 0;
            end
        end
        if (fire) begin
            if (!m_pend || r) begin
                exp_q.push_back(len);
                m_pend = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (cons) begin
            m_pend = 1'b0;
        end
    endtask

    // Drive inputs away from the edge, let one edge pass, advance the model.
    task automatic cyc(input logic [7:0] av, input logic v, input logic r);
        a = av;
        a_vld = v;
        evt_rdy = r;
        @(posedge clk);
        model_step(av, v, r);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_vld = 1'b0;
        evt_rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(MATCH, 1'b1, r);
    endtask

    // Monitor: compare registered outputs with the model; check the event
    // payload against the scoreboard and retire it when the consumer takes it.
    always @(negedge clk) begin
        if (!rst) begin
            chk("hit_cnt", 32'(hit_cnt), m_hits);
            chk("evt_vld", 32'(evt_vld), 32'(m_pend));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("busy", 32'(busy), 32'(m_streak > 0));
            if (evt_vld) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL evt_unexpected: got len %0d expected no event at %0t", evt_len, $time);
                end else begin
                    chk("evt_len", 32'(evt_len), exp_q[0]);
                    if (evt_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_evt_vld", 32'(evt_vld), 0);
        chk("rst_hit_cnt", 32'(hit_cnt), 0);
        chk("rst_busy", 32'(busy), 0);

        // 6 matches then a miss, consumer always ready
        run(4, 1'b1);
        chk("t1_hit_after_4th", 32'(hit_cnt), 1);
        run(2, 1'b1);
        cyc(8'h00, 1'b1, 1'b1);
        chk("t1_evt_vld", 32'(evt_vld), 1);
        chk("t1_evt_len", 32'(evt_len), 6);
        cyc(8'h00, 1'b0, 1'b1);
        chk("t1_evt_pulse", 32'(evt_vld), 0);

        // short run: no event, no hit
        do_reset();
        run(3, 1'b1);
        chk("t2_busy", 32'(busy), 1);
        cyc(8'h10, 1'b1, 1'b1);
        chk("t2_busy_end", 32'(busy), 0);
        chk("t2_hit", 32'(hit_cnt), 0);
        chk("t2_no_evt", 32'(evt_vld), 0);

        // valid strobe toggling
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(MATCH, 1'b1, 1'b1);
            cyc(8'h00, 1'b0, 1'b1);
        end
        cyc(8'h00, 1'b1, 1'b1);
        chk("t3_evt_len", 32'(evt_len), 5);

        // consumer stalled: second event dropped
        do_reset();
        run(4, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        run(7, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        chk("t4_ovf", 32'(ovf), 1);
        chk("t4_held_len", 32'(evt_len), 4);
        cyc(8'h00, 1'b0, 1'b1);
        chk("t4_drained", 32'(evt_vld), 0);
        chk("t4_ovf_sticky", 32'(ovf), 1);

        // consume and load on the same edge
        do_reset();
        run(4, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        run(5, 1'b0);
        cyc(8'h00, 1'b1, 1'b1);
        chk("t5_evt_vld", 32'(evt_vld), 1);
        chk("t5_evt_len", 32'(evt_len), 5);
        chk("t5_ovf", 32'(ovf), 0);
        cyc(8'h00, 1'b0, 1'b1);

        // asynchronous reset mid-LOCK, then a run longer than 255
        do_reset();
        run(5, 1'b1);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_hit", 32'(hit_cnt), 0);
        chk("t6_async_vld", 32'(evt_vld), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(8'h00, 1'b1, 1'b1);
        chk("t6_no_evt", 32'(evt_vld), 0);
        run(300, 1'b1);
        cyc(8'h00, 1'b1, 1'b1);
        chk("t6_sat_len", 32'(evt_len), 255);
        cyc(8'h00, 1'b0, 1'b1);

        // random traffic, long enough to saturate the narrow hit counter
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] rb;
            rb = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : MATCH;
            cyc(rb, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
        end
        chk("rand_hit_sat", 32'(hit_cnt), CNT_MAX);
        repeat (3) cyc(8'h00, 1'b0, 1'b1);
        chk("drain_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
